// File: rtl/axi_stream_packet_source.sv
// AXI-Stream packet source: turns a length/id/dest command plus raw payload words
// into framed AXI-Stream beats with TLAST and a partial-final-beat TKEEP/TSTRB.
//
// state | meaning
// IDLE  | waiting for a packet command, cmd_ready high
// SEND  | accepting payload words and presenting beats on the stream
// DONE  | one-cycle pkt_done pulse after the final beat handshakes
module axi_stream_packet_source #(
   parameter int byte_width = 4,
   parameter int len_width  = 16,
   parameter int id_width   = 4,
   parameter int dest_width = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [len_width-1:0]    cmd_len,
   input  logic [id_width-1:0]     cmd_id,
   input  logic [dest_width-1:0]   cmd_dest,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [8*byte_width-1:0] in_data,
   output logic                    tvalid,
   input  logic                    tready,
   output logic [8*byte_width-1:0] tdata,
   output logic [byte_width-1:0]   tstrb,
   output logic [byte_width-1:0]   tkeep,
   output logic                    tlast,
   output logic [id_width-1:0]     tid,
   output logic [dest_width-1:0]   tdest,
   output logic                    busy,
   output logic                    pkt_done
);

   localparam int LG    = $clog2(byte_width);
   localparam int REM_W = (LG == 0) ? 1 : LG;
   localparam int DW    = 8 * byte_width;

   typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

   state_t                state_q, state_d;
   logic [len_width:0]    total_q;
   logic [len_width:0]    issued_q;
   logic [REM_W-1:0]      rem_q;
   logic [id_width-1:0]   id_q;
   logic [dest_width-1:0] dest_q;

   logic                  tvalid_q;
   logic [DW-1:0]         tdata_q;
   logic [byte_width-1:0] tkeep_q;
   logic                  tlast_q;
   logic [id_width-1:0]   tid_q;
   logic [dest_width-1:0] tdest_q;

   logic                  cmd_fire;
   logic                  in_fire;
   logic                  beat_last;
   logic [len_width:0]    len_rounded;
   logic [len_width:0]    total_next;
   logic [len_width-1:0]  rem_full;
   logic [byte_width-1:0] keep_last;

   // Beat count is computed one bit wider than the length so a full-scale length cannot wrap.
   assign len_rounded = {1'b0, cmd_len} + (len_width+1)'(byte_width - 1);
   assign total_next  = len_rounded >> LG;
   assign rem_full    = cmd_len & len_width'(byte_width - 1);

   assign cmd_fire  = cmd_valid && cmd_ready;
   assign in_fire   = in_valid && in_ready;
   assign beat_last = (issued_q + (len_width+1)'(1)) == total_q;
   assign keep_last = (rem_q == '0) ? {byte_width{1'b1}} : ~({byte_width{1'b1}} << rem_q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (cmd_fire) begin
               state_d = (cmd_len == '0) ? DONE : SEND;
            end
         end
         SEND: begin
            if (tvalid_q && tready && tlast_q) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // cmd_ready is masked by reset so it reads low for the whole reset pulse.
   always_comb begin
      cmd_ready = 1'b0;
      in_ready  = 1'b0;
      busy      = 1'b0;
      pkt_done  = 1'b0;
      case (state_q)
         IDLE: cmd_ready = !reset;
         SEND: begin
            busy     = 1'b1;
            in_ready = (issued_q < total_q) && (!tvalid_q || tready);
         end
         DONE: begin
            busy     = 1'b1;
            pkt_done = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         total_q  <= '0;
         issued_q <= '0;
         rem_q    <= '0;
         id_q     <= '0;
         dest_q   <= '0;
      end else if (cmd_fire) begin
         total_q  <= total_next;
         issued_q <= '0;
         rem_q    <= rem_full[REM_W-1:0];
         id_q     <= cmd_id;
         dest_q   <= cmd_dest;
      end else if (in_fire) begin
         issued_q <= issued_q + (len_width+1)'(1);
      end
   end

   // Output register only reloads when empty or draining, which keeps the payload stable under backpressure.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tvalid_q <= 1'b0;
         tdata_q  <= '0;
         tkeep_q  <= '0;
         tlast_q  <= 1'b0;
         tid_q    <= '0;
         tdest_q  <= '0;
      end else if (in_fire) begin
         tvalid_q <= 1'b1;
         tdata_q  <= in_data;
         tkeep_q  <= beat_last ? keep_last : {byte_width{1'b1}};
         tlast_q  <= beat_last;
         tid_q    <= id_q;
         tdest_q  <= dest_q;
      end else if (tvalid_q && tready) begin
         tvalid_q <= 1'b0;
      end
   end

   assign tvalid = tvalid_q;
   assign tdata  = tdata_q;
   assign tkeep  = tkeep_q;
   assign tstrb  = tkeep_q;
   assign tlast  = tlast_q;
   assign tid    = tid_q;
   assign tdest  = tdest_q;

endmodule

// File: tb/tb_axi_stream_packet_source.sv
// Scoreboard bench for axi_stream_packet_source: beats are predicted when payload words
// are accepted and compared when they handshake on the stream side.
module tb_axi_stream_packet_source;

   localparam int BW = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [15:0] cmd_len;
   logic [3:0]  cmd_id;
   logic [3:0]  cmd_dest;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        tvalid;
   logic        tready;
   logic [31:0] tdata;
   logic [3:0]  tstrb;
   logic [3:0]  tkeep;
   logic        tlast;
   logic [3:0]  tid;
   logic [3:0]  tdest;
   logic        busy;
   logic        pkt_done;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
      logic [3:0]  id;
      logic [3:0]  dest;
   } beat_t;

   beat_t sb[$];
   int    total_n = 0;
   int    bad_n   = 0;

   always #5 clk = ~clk;

   axi_stream_packet_source #(
      .byte_width(BW), .len_width(16), .id_width(4), .dest_width(4)
   ) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
      .cmd_id(cmd_id), .cmd_dest(cmd_dest),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .tvalid(tvalid), .tready(tready), .tdata(tdata), .tstrb(tstrb),
      .tkeep(tkeep), .tlast(tlast), .tid(tid), .tdest(tdest),
      .busy(busy), .pkt_done(pkt_done)
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      total_n++;
      if (act !== exp) begin
         bad_n++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   function automatic logic [3:0] keep_for(input int len, input int idx);
      int left;
      left = len - idx * BW;
      if (left >= BW) return 4'hF;
      if (left <= 0) return 4'h0;
      return 4'((1 << left) - 1);
   endfunction

   // mode 0: full rate, 1: random tready/in_valid, 2: 3-cycle stall on the second beat
   task automatic send_packet(input int len, input logic [3:0] id, input logic [3:0] dest,
                              input int mode, input int abort_after);
      int          total_b;
      int          words;
      int          outs;
      int          stall;
      int          cyc;
      bit          saw_last;
      bit          saw_last_now;
      bit          prev_stall;
      bit          done;
      bit          abort_pend;
      logic [44:0] prev_pl;
      beat_t       b;
      beat_t       e;

      total_b    = (len + BW - 1) / BW;
      words      = 0;
      outs       = 0;
      stall      = 0;
      saw_last   = 0;
      prev_stall = 0;
      done       = 0;
      abort_pend = 0;

      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_len   = 16'(len);
      cmd_id    = id;
      cmd_dest  = dest;
      in_valid  = 1'b0;
      tready    = 1'b1;
      #1;
      for (int w = 0; w < 50 && !cmd_ready; w++) begin
         @(negedge clk);
         #1;
      end
      chk("cmd_ready", cmd_ready, 1);
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_len   = 16'($urandom);
      cmd_id    = 4'($urandom);
      cmd_dest  = 4'($urandom);

      for (cyc = 1; cyc <= 2000 && !done; cyc++) begin
         if (abort_pend) begin
            #2 reset = 1'b1;
            #1;
            chk("rst_tvalid", tvalid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_cmd_ready", cmd_ready, 0);
            chk("rst_tdata", tdata, 0);
            @(negedge clk);
            reset    = 1'b0;
            in_valid = 1'b0;
            sb.delete();
            #1;
            chk("cmd_ready_post_rst", cmd_ready, 1);
            return;
         end
         if (mode == 1) tready = ($urandom_range(0, 2) != 0);
         else if (mode == 2) tready = !(tvalid && outs == 1 && stall < 3);
         else tready = 1'b1;
         if (!tready) stall++;
         in_valid = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
         in_data  = $urandom;
         #1;
         if (cyc == 1) chk("busy_after_cmd", busy, 1);
         if (len == 0) chk("zl_tvalid", tvalid, 0);
         if (saw_last || (len == 0 && cyc == 1)) begin
            chk("pkt_done", pkt_done, 1);
            chk("beat_count", outs, total_b);
            chk("sb_left", sb.size(), 0);
            done = 1;
         end else if (pkt_done) begin
            chk("pkt_done_early", pkt_done, 0);
         end
         if (prev_stall) begin
            chk("hold_valid", tvalid, 1);
            chk("hold_payload", {tdata, tkeep, tlast, tid, tdest}, prev_pl);
         end
         prev_stall = tvalid && !tready;
         if (prev_stall) begin
            prev_pl = {tdata, tkeep, tlast, tid, tdest};
            chk("in_ready_stall", in_ready, 0);
         end
         saw_last_now = 0;
         if (tvalid && tready) begin
            if (sb.size() == 0) begin
               chk("sb_underflow", tvalid, 0);
            end else begin
               e = sb.pop_front();
               chk("tdata", tdata, e.data);
               chk("tkeep", tkeep, e.keep);
               chk("tstrb", tstrb, e.keep);
               chk("tlast", tlast, e.last);
               chk("tid", tid, e.id);
               chk("tdest", tdest, e.dest);
            end
            outs++;
            saw_last_now = tlast;
            if (abort_after > 0 && outs == abort_after) abort_pend = 1;
         end
         saw_last = saw_last_now;
         if (in_valid && in_ready) begin
            b.data = in_data;
            b.keep = keep_for(len, words);
            b.last = (words + 1 == total_b);
            b.id   = id;
            b.dest = dest;
            sb.push_back(b);
            words++;
         end
         if (!done) @(negedge clk);
      end
      if (!done) chk("timeout", done, 1);
      in_valid = 1'b0;
      @(negedge clk);
      #1;
      chk("cmd_ready_after_done", cmd_ready, 1);
      chk("busy_after_done", busy, 0);
   endtask

   initial begin
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_len   = '0;
      cmd_id    = '0;
      cmd_dest  = '0;
      in_valid  = 1'b0;
      in_data   = '0;
      tready    = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_cmd_ready", cmd_ready, 0);
      chk("reset_outs", {in_ready, tvalid, tkeep, tstrb, tlast, tid, tdest, busy, pkt_done}, 0);
      chk("reset_tdata", tdata, 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("release_cmd_ready", cmd_ready, 1);

      send_packet(8, 4'd1, 4'd2, 0, 0);
      send_packet(5, 4'd5, 4'd6, 0, 0);
      send_packet(12, 4'd7, 4'd9, 2, 0);
      send_packet(0, 4'd3, 4'd4, 0, 0);
      send_packet(16, 4'd2, 4'd8, 0, 1);
      send_packet(4, 4'd10, 4'd11, 0, 0);
      for (int p = 0; p < 100; p++) begin
         send_packet($urandom_range(1, 64), 4'($urandom), 4'($urandom), 1, 0);
      end

      $display("test done: total=%0d bad=%0d", total_n, bad_n);
      $finish;
   end

endmodule
